amba_axi_write: RTL and testbench
=================================

Name: amba_axi_write

Overview:
- Single-beat AXI3 write master for the MPEG-2 AAC decoder. Sits between the AAC core and the AMBA-AXI interconnect, next to the read master.
- Accepts one 32-bit write request from the AAC core and drives the AW and W channels independently.
- Collects the B response and reports completion or error back to the AAC core.

Parameters:
AXI_ID, 4'b0000, value driven on awid/wid; bid is checked against it
TIMEOUT, 255, cycles allowed in WAIT_RESP before error; 0 disables timeout

Ports:
aclk  in  1  clock
areset  in  1  asynchronous active-high reset
aacaddr  in  32  write address from AAC core
aacdata  in  32  write data from AAC core
aacstrb  in  4  byte strobes from AAC core
aacwrvalid  in  1  AAC write request
aacwrready  out  1  block idle, request accepted this cycle if aacwrvalid
aacwrdone  out  1  one-cycle pulse, write complete
aacwrerr  out  1  qualifies aacwrdone: SLVERR/DECERR, bid mismatch or timeout
awid  out  4  AXI_ID
awaddr  out  32  write address
awlen  out  4  constant 0 (single beat)
awsize  out  3  constant 3'b010 (4 bytes)
awburst  out  2  constant 2'b01 (INCR)
awlock  out  2  constant 2'b00
awcache  out  4  constant 4'b0001
awprot  out  3  constant 3'b010
awvalid  out  1  address valid
awready  in  1  address accepted
wid  out  4  AXI_ID
wdata  out  32  write data
wstrb  out  4  byte strobes
wlast  out  1  constant 1 while wvalid
wvalid  out  1  data valid
wready  in  1  data accepted
bid  in  4  response id
bresp  in  2  response code
bvalid  in  1  response valid
bready  out  1  response ready

Behaviour:
- Clock and reset: one clock, aclk. Reset is asynchronous and active-high on areset.
- Reset values: state IDLE; aacwrready=1; aacwrdone=0; aacwrerr=0; awvalid=0; wvalid=0; bready=0; awaddr=0; wdata=0; wstrb=0; timeout counter=0. All outputs are registered.
- IDLE:
  - aacwrready=1.
  - On aacwrvalid: latch aacaddr, aacdata, aacstrb into awaddr, wdata, wstrb.
  - Next cycle: awvalid=1, wvalid=1, aacwrready=0. Go to SEND.
- SEND (AW and W tracked independently):
  - awvalid drops the cycle after an awready&awvalid handshake.
  - wvalid drops the cycle after a wready&wvalid handshake.
  - Both may complete in the same cycle, or either may complete first, in any order.
  - awaddr, wdata and wstrb stay stable while the matching valid is high. AXI rule: a valid, once asserted, never drops before its ready.
  - When both handshakes are complete: bready=1, counter cleared, go to WAIT_RESP.
- WAIT_RESP:
  - On bvalid&bready: bready=0, go to DONE.
  - Latch err = (bresp[1]==1) | (bid!=AXI_ID).
  - The counter increments each cycle without bvalid. If TIMEOUT!=0 and the counter reaches TIMEOUT: bready=0, err=1, go to DONE.
  - A late bvalid after timeout is ignored; bready stays 0.
- DONE: aacwrdone=1 and aacwrerr=err for exactly one cycle, then IDLE with aacwrready=1. A request is not accepted in the DONE cycle.
- Latency, zero-wait slave: request accepted at cycle 0; AW/W valid at 1; handshake at 1; bready at 2; bvalid at 2; aacwrdone at 4.
- aacwrvalid while not idle is ignored; the request is not buffered.
- bresp EXOKAY (2'b01) is treated as OKAY.
- Reset mid-operation aborts immediately to reset values. No aacwrdone is emitted for the aborted write.

Test Plan:
- Zero-wait slave (awready=wready=bvalid=1, bresp=00, bid=0), write 0x0000_1000 ← 0xDEADBEEF, strb 4'hF → awaddr=0x1000, wdata=0xDEADBEEF, wlast=1, aacwrdone pulse 4 cycles after request, aacwrerr=0.
- awready delayed 5 cycles, wready immediate → wvalid drops after 1 cycle; awvalid and awaddr held stable 5 cycles; bready only after AW handshake; done with aacwrerr=0.
- wready delayed 3 cycles, awready immediate, strb 4'b0011 → wstrb=0011 and wdata held stable until handshake; single done pulse.
- bresp=2'b10 (SLVERR), then a separate write with bid=4'h3 and bresp OKAY → aacwrdone with aacwrerr=1 for each.
- TIMEOUT=8, bvalid never asserted → aacwrdone&aacwrerr 9 cycles after entering WAIT_RESP; bready=0 afterwards; next write completes normally.
- areset pulsed while awvalid=1 → all outputs at reset values within the same cycle (async); no aacwrdone; aacwrready=1 after reset release.

Source files
------------

// File: rtl/amba_axi_write.sv
// ----------------------------------------------------------------------------
// amba_axi_write
//   Single-beat AXI3 write master for the MPEG-2 AAC decoder. Takes one 32-bit
//   write request from the AAC core, drives the AW and W channels
//   independently, collects the B response and reports completion/error.
//
// Ports
//   aclk, areset              clock, asynchronous active-high reset
//   aacaddr/aacdata/aacstrb   write request payload from the AAC core
//   aacwrvalid / aacwrready   request handshake (ready only while idle)
//   aacwrdone / aacwrerr      one-cycle completion pulse, error qualifier
//   aw*                       AXI3 write address channel (single beat, INCR)
//   w*                        AXI3 write data channel (wlast follows wvalid)
//   bid/bresp/bvalid/bready   AXI3 write response channel
// ----------------------------------------------------------------------------
module amba_axi_write #(
   parameter logic [3:0]  AXI_ID  = 4'b0000,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic [31:0] aacaddr,
   input  logic [31:0] aacdata,
   input  logic [3:0]  aacstrb,
   input  logic        aacwrvalid,
   output logic        aacwrready,
   output logic        aacwrdone,
   output logic        aacwrerr,
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [3:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic [1:0]  awlock,
   output logic [3:0]  awcache,
   output logic [2:0]  awprot,
   output logic        awvalid,
   input  logic        awready,
   output logic [3:0]  wid,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   input  logic [3:0]  bid,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready
);

   localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   // S_CAPTURE holds the latched response for one cycle before the done pulse;
   // a timeout skips it and goes straight to S_DONE.
   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_WAIT_RESP,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t          r_state, w_state_nxt;
   logic            r_ready, w_ready_nxt;
   logic            r_done, w_done_nxt;
   logic            r_wrerr, w_wrerr_nxt;
   logic            r_err, w_err_nxt;
   logic            r_awvalid, w_awvalid_nxt;
   logic            r_wvalid, w_wvalid_nxt;
   logic            r_bready, w_bready_nxt;
   logic [31:0]     r_awaddr, w_awaddr_nxt;
   logic [31:0]     r_wdata, w_wdata_nxt;
   logic [3:0]      r_wstrb, w_wstrb_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic            w_resp_err;

   // SLVERR (10) and DECERR (11) are errors; OKAY and EXOKAY are not.
   assign w_resp_err = (bresp == 2'b10) || (bresp == 2'b11) || (bid != AXI_ID);

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state   <= S_IDLE;
         r_ready   <= 1'b1;
         r_done    <= 1'b0;
         r_wrerr   <= 1'b0;
         r_err     <= 1'b0;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_bready  <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_cnt     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_ready   <= w_ready_nxt;
         r_done    <= w_done_nxt;
         r_wrerr   <= w_wrerr_nxt;
         r_err     <= w_err_nxt;
         r_awvalid <= w_awvalid_nxt;
         r_wvalid  <= w_wvalid_nxt;
         r_bready  <= w_bready_nxt;
         r_awaddr  <= w_awaddr_nxt;
         r_wdata   <= w_wdata_nxt;
         r_wstrb   <= w_wstrb_nxt;
         r_cnt     <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_ready_nxt   = r_ready;
      w_done_nxt    = 1'b0;
      w_wrerr_nxt   = 1'b0;
      w_err_nxt     = r_err;
      w_awvalid_nxt = r_awvalid;
      w_wvalid_nxt  = r_wvalid;
      w_bready_nxt  = r_bready;
      w_awaddr_nxt  = r_awaddr;
      w_wdata_nxt   = r_wdata;
      w_wstrb_nxt   = r_wstrb;
      w_cnt_nxt     = r_cnt;

      case (r_state)
         S_IDLE: begin
            w_ready_nxt = 1'b1;
            if (aacwrvalid) begin
               w_awaddr_nxt  = aacaddr;
               w_wdata_nxt   = aacdata;
               w_wstrb_nxt   = aacstrb;
               w_awvalid_nxt = 1'b1;
               w_wvalid_nxt  = 1'b1;
               w_ready_nxt   = 1'b0;
               w_err_nxt     = 1'b0;
               w_state_nxt   = S_SEND;
            end
         end

         S_SEND: begin
            // Each channel retires on its own handshake; leave once both are gone.
            if (r_awvalid && awready) w_awvalid_nxt = 1'b0;
            if (r_wvalid && wready)   w_wvalid_nxt  = 1'b0;
            if (!w_awvalid_nxt && !w_wvalid_nxt) begin
               w_bready_nxt = 1'b1;
               w_cnt_nxt    = '0;
               w_state_nxt  = S_WAIT_RESP;
            end
         end

         S_WAIT_RESP: begin
            if (bvalid) begin
               w_bready_nxt = 1'b0;
               w_err_nxt    = w_resp_err;
               w_state_nxt  = S_CAPTURE;
            end else if ((TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT))) begin
               w_bready_nxt = 1'b0;
               w_err_nxt    = 1'b1;
               w_done_nxt   = 1'b1;
               w_wrerr_nxt  = 1'b1;
               w_state_nxt  = S_DONE;
            end else if (TIMEOUT != 0) begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end

         S_CAPTURE: begin
            w_done_nxt  = 1'b1;
            w_wrerr_nxt = r_err;
            w_state_nxt = S_DONE;
         end

         S_DONE: begin
            w_ready_nxt = 1'b1;
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_ready_nxt = 1'b1;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign aacwrready = r_ready;
   assign aacwrdone  = r_done;
   assign aacwrerr   = r_wrerr;

   assign awid    = AXI_ID;
   assign awaddr  = r_awaddr;
   assign awlen   = 4'b0000;
   assign awsize  = 3'b010;
   assign awburst = 2'b01;
   assign awlock  = 2'b00;
   assign awcache = 4'b0001;
   assign awprot  = 3'b010;
   assign awvalid = r_awvalid;

   assign wid    = AXI_ID;
   assign wdata  = r_wdata;
   assign wstrb  = r_wstrb;
   assign wlast  = r_wvalid;
   assign wvalid = r_wvalid;

   assign bready = r_bready;

endmodule

// File: tb/tb_amba_axi_write.sv
module tb_amba_axi_write;

   logic        aclk;
   logic        areset;
   logic [31:0] aacaddr;
   logic [31:0] aacdata;
   logic [3:0]  aacstrb;
   logic        aacwrvalid;
   logic        aacwrready;
   logic        aacwrdone;
   logic        aacwrerr;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [3:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [1:0]  awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   amba_axi_write #(.AXI_ID(4'b0000), .TIMEOUT(8)) dut (
      .aclk(aclk), .areset(areset),
      .aacaddr(aacaddr), .aacdata(aacdata), .aacstrb(aacstrb),
      .aacwrvalid(aacwrvalid), .aacwrready(aacwrready),
      .aacwrdone(aacwrdone), .aacwrerr(aacwrerr),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
      .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic        err;
   } exp_t;
   exp_t sb[$];

   // Slave behaviour knobs
   int          aw_wait = 0;
   int          w_wait  = 0;
   logic        b_en    = 1'b1;
   logic        b_force = 1'b0;
   logic [3:0]  b_id    = 4'h0;
   logic [1:0]  b_resp  = 2'b00;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // AXI slave model: ready after a programmable number of valid cycles
   int aw_cnt = 0;
   int w_cnt  = 0;
   initial begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = 4'h0; bresp = 2'b00;
      forever begin
         @(negedge aclk);
         if (awvalid) begin awready = (aw_cnt >= aw_wait); aw_cnt++; end
         else begin awready = 1'b0; aw_cnt = 0; end
         if (wvalid) begin wready = (w_cnt >= w_wait); w_cnt++; end
         else begin wready = 1'b0; w_cnt = 0; end
         if (b_force || (bready && b_en)) begin bvalid = 1'b1; bid = b_id; bresp = b_resp; end
         else bvalid = 1'b0;
      end
   end

   // Channel monitor / scoreboard consumer
   logic prev_aw = 1'b0;
   logic prev_w  = 1'b0;
   initial begin
      forever begin
         @(negedge aclk);
         #1;
         if (areset) begin
            prev_aw = 1'b0;
            prev_w  = 1'b0;
         end else begin
            if (prev_aw) chk("awvalid_hold", awvalid, 1);
            if (prev_w)  chk("wvalid_hold", wvalid, 1);
            if (awvalid) begin
               chk("aw_sb_depth", sb.size(), 1);
               if (sb.size() > 0) chk("awaddr", awaddr, sb[0].addr);
               chk("aw_ctrl", {awid, awlen, awsize, awburst, awlock, awcache, awprot},
                   {4'h0, 4'h0, 3'b010, 2'b01, 2'b00, 4'b0001, 3'b010});
            end
            if (wvalid) begin
               chk("w_sb_depth", sb.size(), 1);
               if (sb.size() > 0) begin
                  chk("wdata", wdata, sb[0].data);
                  chk("wstrb", wstrb, sb[0].strb);
               end
               chk("wlast_wid", {wlast, wid}, {1'b1, 4'h0});
            end
            if (aacwrdone) begin
               chk("done_sb_depth", sb.size(), 1);
               if (sb.size() > 0) begin
                  exp_t e;
                  e = sb.pop_front();
                  chk("aacwrerr", aacwrerr, e.err);
               end
            end else begin
               chk("err_without_done", aacwrerr, 0);
            end
            prev_aw = awvalid && !awready;
            prev_w  = wvalid && !wready;
         end
      end
   end

   // Called at a negedge; returns at the negedge of cycle 1 (cycle 0 = accept)
   task automatic start_write(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic e, output int lat);
      int n;
      n = 0;
      while (!aacwrready && n < 50) begin @(negedge aclk); n++; end
      chk("req_ready", aacwrready, 1);
      aacaddr = a; aacdata = d; aacstrb = s; aacwrvalid = 1'b1;
      sb.push_back('{addr: a, data: d, strb: s, err: e});
      @(negedge aclk);
      aacwrvalid = 1'b0;
      lat = 1;
   endtask

   task automatic wait_done(inout int lat);
      while (!aacwrdone && lat < 200) begin @(negedge aclk); lat++; end
      chk("done_seen", aacwrdone, 1);
   endtask

   int lat;
   int n;

   initial begin
      areset = 1'b1; aacaddr = '0; aacdata = '0; aacstrb = '0; aacwrvalid = 1'b0;
      @(negedge aclk);
      chk("rst_outputs", {aacwrready, aacwrdone, aacwrerr, awvalid, wvalid, bready},
          6'b100000);
      chk("rst_payload", {awaddr, wdata, wstrb}, 68'h0);
      @(negedge aclk);
      areset = 1'b0;
      @(negedge aclk);

      // Zero-wait slave
      start_write(32'h0000_1000, 32'hDEADBEEF, 4'hF, 1'b0, lat);
      chk("t1_c1_valids", {awvalid, wvalid, aacwrready, wlast}, 4'b1101);
      @(negedge aclk); lat++;
      chk("t1_c2_bready", {bready, awvalid, wvalid}, 3'b100);
      wait_done(lat);
      chk("t1_latency", lat, 4);
      @(negedge aclk);
      chk("t1_single_pulse", {aacwrdone, aacwrready}, 2'b01);

      // awready delayed, wready immediate
      aw_wait = 5;
      start_write(32'h0000_2004, 32'h1234_5678, 4'hF, 1'b0, lat);
      @(negedge aclk); lat++;
      chk("t2_c2_state", {awvalid, wvalid, bready}, 3'b100);
      wait_done(lat);
      chk("t2_latency", lat, 9);
      aw_wait = 0;

      // wready delayed, awready immediate, partial strobe
      w_wait = 3;
      start_write(32'h0000_3008, 32'hCAFE_F00D, 4'b0011, 1'b0, lat);
      @(negedge aclk); lat++;
      chk("t3_c2_state", {awvalid, wvalid, bready, wstrb}, {3'b010, 4'b0011});
      wait_done(lat);
      chk("t3_latency", lat, 7);
      @(negedge aclk);
      chk("t3_single_pulse", aacwrdone, 0);
      w_wait = 0;

      // Error responses
      b_resp = 2'b10;
      start_write(32'h0000_4000, 32'h0000_0001, 4'hF, 1'b1, lat);
      wait_done(lat);
      chk("t4_slverr_latency", lat, 4);
      b_resp = 2'b00; b_id = 4'h3;
      start_write(32'h0000_4004, 32'h0000_0002, 4'hF, 1'b1, lat);
      wait_done(lat);
      b_id = 4'h0; b_resp = 2'b01;
      start_write(32'h0000_4008, 32'h0000_0003, 4'hF, 1'b0, lat);
      wait_done(lat);
      b_resp = 2'b00;

      // Timeout: no bvalid
      b_en = 1'b0;
      start_write(32'h0000_5000, 32'h5555_AAAA, 4'hF, 1'b1, lat);
      n = 0;
      while (!bready && n < 50) begin @(negedge aclk); n++; end
      chk("t5_bready_seen", bready, 1);
      n = 0;
      while (!aacwrdone && n < 50) begin @(negedge aclk); n++; end
      chk("t5_timeout_latency", n, 9);
      chk("t5_bready_low", bready, 0);
      b_force = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge aclk);
         chk("t5_late_bvalid", {bready, aacwrdone}, 2'b00);
      end
      b_force = 1'b0;
      b_en = 1'b1;
      start_write(32'h0000_5004, 32'h0BAD_F00D, 4'hF, 1'b0, lat);
      wait_done(lat);
      chk("t5_recover_latency", lat, 4);

      // Reset while awvalid is high
      aw_wait = 100;
      start_write(32'h0000_6000, 32'h6666_6666, 4'hF, 1'b0, lat);
      chk("t6_awvalid_before", awvalid, 1);
      #2;
      areset = 1'b1;
      #1;
      chk("t6_async_ctrl", {aacwrready, aacwrdone, aacwrerr, awvalid, wvalid, bready},
          6'b100000);
      chk("t6_async_payload", {awaddr, wdata, wstrb}, 68'h0);
      sb.delete();
      aw_wait = 0;
      @(negedge aclk);
      @(negedge aclk);
      areset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge aclk);
         chk("t6_no_done", aacwrdone, 0);
      end
      chk("t6_ready_after", aacwrready, 1);
      start_write(32'h0000_7000, 32'h7777_0000, 4'b1100, 1'b0, lat);
      wait_done(lat);
      chk("t6_post_reset_latency", lat, 4);

      @(negedge aclk);
      @(negedge aclk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
